prob1_sched: RTL and testbench

- Round-robin scheduler that shares one byte-scan counter datapath (8-bit data_in, clk, rst, 3-bit count_out) between two requesters.
- Sequences each job automatically: latch the byte, pulse the datapath reset, wait a fixed settle window, capture the count, return it tagged with the requester id.
- Sits between the requester logic and the counter instance.

---
 rtl/prob1_sched.sv | 141 ++++++++++++++
 tb/tb_prob1_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prob1_sched.sv
// prob1_sched: round-robin front end that time-shares one byte-scan counter
// datapath between two requesters.
//
// Each accepted job runs four steps. The scheduler latches the byte and
// pulses the datapath reset for one cycle. It then lets the datapath run for
// WAIT_CYC cycles and captures the count. Finally it holds that count, tagged
// with the requester id, until the consumer takes it.
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   reqN_valid/data/ready  requester N handshake (N = 0, 1); ready is combinational
//   dp_data, dp_rst        byte and reset pulse driven to the datapath
//   dp_count               datapath count, sampled only on the capture edge
//   res_valid/data/id      result handshake towards the consumer
//   res_ready              consumer accepts the result
//   busy                   high whenever a job is in flight
module prob1_sched #(
    parameter int unsigned DW       = 8,
    parameter int unsigned CW       = 3,
    parameter int unsigned WAIT_CYC = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [DW-1:0] dp_data,
    output logic          dp_rst,
    input  logic [CW-1:0] dp_count,
    output logic          res_valid,
    output logic [CW-1:0] res_data,
    output logic          res_id,
    input  logic          res_ready,
    output logic          busy
);

    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StReport
    } state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            res_valid_q, res_valid_d;
    logic [CW-1:0]   res_data_q, res_data_d;
    logic            res_id_q, res_id_d;
    logic [DW-1:0]   dp_data_q, dp_data_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic grant0, grant1;

    // A lone requester always wins. On contention, the requester that was
    // not granted last time wins.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    assign req0_ready = (state_q == StIdle) & grant0 & ~rst;
    assign req1_ready = (state_q == StIdle) & grant1 & ~rst;

    // The global reset also clears the datapath.
    assign dp_rst    = rst | (state_q == StLoad);
    assign busy      = (state_q != StIdle);
    assign dp_data   = dp_data_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        dp_data_d    = dp_data_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (grant0) begin
                    dp_data_d    = req0_data;
                    res_id_d     = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = StLoad;
                end else if (grant1) begin
                    dp_data_d    = req1_data;
                    res_id_d     = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    res_data_d  = dp_count;
                    res_valid_d = 1'b1;
                    state_d     = StReport;
                end
            end
            StReport: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            dp_data_q    <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            dp_data_q    <= dp_data_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_prob1_sched.sv
// Bench for prob1_sched.
// Instance A uses WAIT_CYC=10 with a stub that returns data[2:0] a few cycles
// after dp_rst. Instance B uses WAIT_CYC=1 with a stub that loads data[2:0] on
// dp_rst and then increments, so the sampled value shows which edge captured it.
module tb_prob1_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A signals
    logic       a_req0_valid, a_req1_valid, a_req0_ready, a_req1_ready;
    logic [7:0] a_req0_data, a_req1_data, a_dp_data;
    logic       a_dp_rst, a_res_valid, a_res_id, a_res_ready, a_busy;
    logic [2:0] a_dp_count, a_res_data;
    logic [2:0] a_stub_q;
    logic [1:0] a_dly_q;
    logic       a_corrupt;

    // Instance B signals
    logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [7:0] b_req0_data, b_req1_data, b_dp_data;
    logic       b_dp_rst, b_res_valid, b_res_id, b_res_ready, b_busy;
    logic [2:0] b_dp_count, b_res_data;
    logic [2:0] b_stub_q;

    prob1_sched #(.DW(8), .CW(3), .WAIT_CYC(10)) u_a (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (a_req0_valid),
        .req0_data  (a_req0_data),
        .req0_ready (a_req0_ready),
        .req1_valid (a_req1_valid),
        .req1_data  (a_req1_data),
        .req1_ready (a_req1_ready),
        .dp_data    (a_dp_data),
        .dp_rst     (a_dp_rst),
        .dp_count   (a_dp_count),
        .res_valid  (a_res_valid),
        .res_data   (a_res_data),
        .res_id     (a_res_id),
        .res_ready  (a_res_ready),
        .busy       (a_busy)
    );

    prob1_sched #(.DW(8), .CW(3), .WAIT_CYC(1)) u_b (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (b_req0_valid),
        .req0_data  (b_req0_data),
        .req0_ready (b_req0_ready),
        .req1_valid (b_req1_valid),
        .req1_data  (b_req1_data),
        .req1_ready (b_req1_ready),
        .dp_data    (b_dp_data),
        .dp_rst     (b_dp_rst),
        .dp_count   (b_dp_count),
        .res_valid  (b_res_valid),
        .res_data   (b_res_data),
        .res_id     (b_res_id),
        .res_ready  (b_res_ready),
        .busy       (b_busy)
    );

    always @(posedge clk) begin
        if (a_dp_rst) begin
            a_dly_q  <= 2'd0;
            a_stub_q <= 3'd0;
        end else if (a_dly_q != 2'd3) begin
            a_dly_q <= a_dly_q + 2'd1;
        end else begin
            a_stub_q <= a_dp_data[2:0];
        end
    end
    assign a_dp_count = a_stub_q ^ {3{a_corrupt}};

    always @(posedge clk) begin
        if (b_dp_rst) b_stub_q <= b_dp_data[2:0];
        else          b_stub_q <= b_stub_q + 3'd1;
    end
    assign b_dp_count = b_stub_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one instance-A job with res_ready held high. It is entered just
    // after a falling edge with the DUT in IDLE.
    task automatic run_job(input logic v0, input logic [7:0] d0, input logic v1,
                           input logic [7:0] d1, input int exp_id,
                           input logic [2:0] exp_res, input logic [7:0] exp_dp);
        int k;
        int rst_cyc;
        a_req0_valid = v0;
        a_req0_data  = d0;
        a_req1_valid = v1;
        a_req1_data  = d1;
        a_res_ready  = 1'b1;
        #1;
        chk("idle_busy", a_busy, 0);
        chk("grant_ready0", a_req0_ready, (exp_id == 0));
        chk("grant_ready1", a_req1_ready, (exp_id == 1));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("load_dp_rst", a_dp_rst, 1);
        chk("load_busy", a_busy, 1);
        chk("load_dp_data", a_dp_data, exp_dp);
        chk("load_ready", {a_req0_ready, a_req1_ready}, 0);
        k = 0;
        rst_cyc = 1;
        while (!a_res_valid && k < 40) begin
            @(negedge clk);
            #1;
            k++;
            if (a_dp_rst) rst_cyc++;
        end
        chk("latency", k, 11);
        chk("dp_rst_len", rst_cyc, 1);
        chk("res_data", a_res_data, exp_res);
        chk("res_id", a_res_id, exp_id);
        @(negedge clk);
        #1;
        chk("done_res_valid", a_res_valid, 0);
        chk("done_busy", a_busy, 0);
        a_req0_valid = 1'b0;
        a_req1_valid = 1'b0;
    endtask

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        int         exp_id;
        logic [2:0] exp_res;
        logic [7:0] exp_dp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        // Contention alternates 0,1,0,1. Then one requester is granted back-to-back.
        vecs[0] = '{1'b1, 8'h4C, 1'b1, 8'h20, 0, 3'b100, 8'h4C};
        vecs[1] = '{1'b1, 8'h4C, 1'b1, 8'h20, 1, 3'b000, 8'h20};
        vecs[2] = '{1'b1, 8'h4C, 1'b1, 8'h20, 0, 3'b100, 8'h4C};
        vecs[3] = '{1'b1, 8'h4C, 1'b1, 8'h20, 1, 3'b000, 8'h20};
        vecs[4] = '{1'b1, 8'h2D, 1'b0, 8'h00, 0, 3'b101, 8'h2D};
        vecs[5] = '{1'b1, 8'h4C, 1'b0, 8'h00, 0, 3'b100, 8'h4C};

        rst = 1'b1;
        a_req0_valid = 1'b1;
        a_req0_data  = 8'h11;
        a_req1_valid = 1'b1;
        a_req1_data  = 8'h22;
        a_res_ready  = 1'b1;
        a_corrupt    = 1'b0;
        b_req0_valid = 1'b0;
        b_req0_data  = 8'h00;
        b_req1_valid = 1'b0;
        b_req1_data  = 8'h00;
        b_res_ready  = 1'b1;

        // Reset state. Ready stays low even with valid high.
        #2;
        chk("rst_res_valid", a_res_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_dp_data", a_dp_data, 0);
        chk("rst_dp_rst", a_dp_rst, 1);
        chk("rst_ready", {a_req0_ready, a_req1_ready}, 0);
        chk("rst_res", {a_res_data, a_res_id}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        a_req0_valid = 1'b0;
        a_req1_valid = 1'b0;
        #1;
        chk("post_rst_dp_rst", a_dp_rst, 0);

        // Start a req1 job, then hit it with an asynchronous reset mid-RUN.
        a_req1_valid = 1'b1;
        a_req1_data  = 8'h77;
        #1;
        chk("midrst_ready1", a_req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a_req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("midrst_busy_pre", a_busy, 1);
        chk("midrst_dp_data_pre", a_dp_data, 8'h77);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_res_valid", a_res_valid, 0);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_dp_data", a_dp_data, 0);
        chk("midrst_dp_rst", a_dp_rst, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // After the release, req0 wins first on contention.
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1,
                    vecs[i].exp_id, vecs[i].exp_res, vecs[i].exp_dp);
        end

        // Backpressure, with req1 changing its data while it waits.
        a_req0_valid = 1'b1;
        a_req0_data  = 8'h2D;
        a_res_ready  = 1'b0;
        #1;
        chk("bp_ready0", a_req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a_req0_valid = 1'b0;
        a_req1_valid = 1'b1;
        a_req1_data  = 8'h80;
        #1;
        k = 0;
        while (!a_res_valid && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("bp_latency", k, 11);
        chk("bp_res_data", a_res_data, 3'b101);
        a_req1_data = 8'hEC;
        a_corrupt   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", a_res_valid, 1);
            chk("bp_hold_data", a_res_data, 3'b101);
            chk("bp_hold_id", a_res_id, 0);
            chk("bp_hold_ready1", a_req1_ready, 0);
        end
        a_res_ready = 1'b1;
        a_corrupt   = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_idle_busy", a_busy, 0);
        chk("bp_idle_valid", a_res_valid, 0);
        chk("bp_idle_ready1", a_req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a_req1_valid = 1'b0;
        #1;
        chk("chg_dp_data", a_dp_data, 8'hEC);
        chk("chg_res_id", a_res_id, 1);
        k = 0;
        while (!a_res_valid && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("chg_latency", k, 11);
        chk("chg_res_data", a_res_data, 3'b100);
        @(negedge clk);
        #1;
        chk("chg_done", a_busy, 0);

        // WAIT_CYC=1: the result appears two cycles after acceptance, and the
        // count comes from the first RUN edge.
        b_req0_valid = 1'b1;
        b_req0_data  = 8'h05;
        #1;
        chk("w1_ready0", b_req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        b_req0_valid = 1'b0;
        #1;
        chk("w1_dp_rst", b_dp_rst, 1);
        k = 0;
        while (!b_res_valid && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("w1_latency", k, 2);
        chk("w1_res_data", b_res_data, 3'd5);
        chk("w1_res_id", b_res_id, 0);
        @(negedge clk);
        #1;
        chk("w1_done", {b_res_valid, b_busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
